uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter_pkg.sv | 18 +
 rtl/uart_tx_bit_timer.sv | 28 ++
 rtl/uart_transmitter.sv | 149 ++++++++++++++
 tb/tb_uart_transmitter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART timing constants, used by both the transmit and receive paths.
package uart_transmitter_pkg;

  // Baud-tick strobes per serial bit (16x oversampling).
  localparam int COUNT_16 = 16;

  // Width of the per-bit tick counter.
  localparam int TICK_W = $clog2(COUNT_16);

  typedef logic [TICK_W-1:0] tick_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts baud strobes and flags the strobe that ends a bit.
module uart_tx_bit_timer
  import uart_transmitter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic strobe,
  output logic bit_end
);

  localparam tick_t TICK_LAST = tick_t'(COUNT_16 - 1);

  tick_t count;

  // Tick counter: held at zero while cleared, otherwise advances on each strobe
  // and wraps naturally from the last tick back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (strobe) begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = strobe && (count == TICK_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one word per request into start, LSB-first data,
// optional parity and stop bit(s), timed by a 16x baud strobe.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_in_pos_edge,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 timer_clear;
  logic                 bit_end;

  // Parity of the word being sent, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction

  // The timer only runs inside bit states; holding it clear in IDLE also
  // drops a strobe that coincides with the accepting edge.
  assign timer_clear = (state == ST_IDLE) || (state == ST_DONE);

  uart_tx_bit_timer u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .strobe  (baud_in_pos_edge),
    .bit_end (bit_end)
  );

  // Frame sequencer: tx_serial is registered and updated on the same edge as
  // the state/bit change, so the line never lags the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_serial <= 1'b1;
          tx_done   <= 1'b0;
          if (tx_start) begin
            shift_reg  <= tx_data;
            parity_bit <= calc_parity(tx_data);
            bit_idx    <= '0;
            tx_serial  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            bit_idx   <= '0;
            tx_serial <= shift_reg[0];
            state     <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx_serial <= parity_bit;
                state     <= ST_PARITY;
              end else begin
                tx_serial <= 1'b1;
                state     <= ST_STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              // The next LSB is the bit about to be shifted into position 0.
              tx_serial <= shift_reg[1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            bit_idx   <= '0;
            tx_serial <= 1'b1;
            state     <= ST_STOP;
          end
        end

        ST_STOP: begin
          tx_serial <= 1'b1;
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              tx_done <= 1'b1;
              state   <= ST_DONE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Single-cycle completion; any request seen here is dropped.
          tx_serial <= 1'b1;
          tx_done   <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          tx_serial <= 1'b1;
          tx_done   <= 1'b0;
          busy      <= 1'b0;
          bit_idx   <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: four parameterisations share one
// clock, reset and baud strobe; a bit-level scoreboard checks every frame.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  int         sel = 0;
  int         cyc = 0;
  logic       baud;

  logic [3:0] st_v;
  logic [3:0] ser;
  logic [3:0] bsy;
  logic [3:0] dn;
  logic       obs_ser, obs_busy, obs_done;

  int total = 0;
  int bad = 0;

  logic exp_q[$];

  // Per-instance frame format: data bits, parity enable, parity odd, stop bits.
  int nd_t[4] = '{8, 8, 8, 7};
  int pe_t[4] = '{0, 1, 1, 0};
  int po_t[4] = '{0, 0, 1, 0};
  int ns_t[4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  // Free-running cycle counter; the baud strobe is one cycle in four.
  always @(posedge clk) cyc <= cyc + 1;
  assign baud = (cyc % 4 == 3);

  assign st_v[0] = tx_start && (sel == 0);
  assign st_v[1] = tx_start && (sel == 1);
  assign st_v[2] = tx_start && (sel == 2);
  assign st_v[3] = tx_start && (sel == 3);

  assign obs_ser  = ser[sel[1:0]];
  assign obs_busy = bsy[sel[1:0]];
  assign obs_done = dn[sel[1:0]];

  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .baud_in_pos_edge(baud), .tx_start(st_v[0]),
    .tx_data(tx_data), .tx_serial(ser[0]), .busy(bsy[0]), .tx_done(dn[0]));

  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .baud_in_pos_edge(baud), .tx_start(st_v[1]),
    .tx_data(tx_data), .tx_serial(ser[1]), .busy(bsy[1]), .tx_done(dn[1]));

  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .baud_in_pos_edge(baud), .tx_start(st_v[2]),
    .tx_data(tx_data), .tx_serial(ser[2]), .busy(bsy[2]), .tx_done(dn[2]));

  uart_transmitter #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .baud_in_pos_edge(baud), .tx_start(st_v[3]),
    .tx_data(tx_data[6:0]), .tx_serial(ser[3]), .busy(bsy[3]), .tx_done(dn[3]));

  // Reference frame for the selected instance, pushed when the word is offered.
  task automatic push_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd_t[sel]; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe_t[sel] != 0) exp_q.push_back(1'((ones % 2) ^ po_t[sel]));
    for (int i = 0; i < ns_t[sel]; i++) exp_q.push_back(1'b1);
  endtask

  // mode: 0 any cycle, 1 coincident with a strobe, 2 away from a strobe,
  // 3 right now (caller is already on a falling edge).
  task automatic send(input logic [7:0] d, input int mode);
    if (mode != 3) @(negedge clk);
    if (mode == 1) while (!baud) @(negedge clk);
    if (mode == 2) while (baud) @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    push_frame(d);
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Follows one frame from the cycle after acceptance, comparing every bit
  // against the scoreboard over its full 16-strobe window.
  task automatic run_frame(input string name, input int exp_cycles, input int exp_rise,
                           input int inject_mid, input bit inject_done, input int reset_at);
    int   strobes, cyc_since, rise, nbits;
    logic prev, exp_bit, bad_bit;
    bit   injected;
    strobes = 0; cyc_since = 0; rise = -1; injected = 0;
    nbits = exp_q.size();
    for (int k = 0; k < nbits; k++) begin
      exp_bit = exp_q.pop_front();
      bad_bit = 1'b0;
      while (strobes < 16 * (k + 1)) begin
        if (reset_at >= 0 && strobes == reset_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          total++;
          if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
            bad++;
            $display("FAIL %s reset_mid: serial=%b busy=%b done=%b, want 1 0 0",
                     name, obs_ser, obs_busy, obs_done);
          end
          bad_bit = 1'b0;
          for (int c = 0; c < 200; c++) begin
            if (obs_done !== 1'b0 || obs_ser !== 1'b1 || obs_busy !== 1'b0) bad_bit = 1'b1;
            @(negedge clk);
          end
          total++;
          if (bad_bit) begin
            bad++;
            $display("FAIL %s reset_quiet: line not idle after reset, got activity want idle", name);
          end
          exp_q.delete();
          return;
        end
        if (obs_ser !== exp_bit || obs_busy !== 1'b1 || obs_done !== 1'b0) bad_bit = 1'b1;
        if (rise < 0 && obs_ser === 1'b1) rise = cyc_since;
        if (inject_mid >= 0 && !injected && strobes == inject_mid) begin
          tx_start = 1'b1;
          tx_data  = 8'h3C;
          injected = 1;
        end
        prev = baud;
        @(negedge clk);
        tx_start = 1'b0;
        cyc_since++;
        if (prev) strobes++;
        if (cyc_since > 5000) begin
          total++;
          bad++;
          $display("FAIL %s timeout: frame still running after %0d cycles, want done", name, cyc_since);
          exp_q.delete();
          return;
        end
      end
      total++;
      if (bad_bit) begin
        bad++;
        $display("FAIL %s bit%0d: serial=%b busy=%b done=%b at end, want serial=%b busy=1 done=0",
                 name, k, obs_ser, obs_busy, obs_done, exp_bit);
      end
    end
    total++;
    if (obs_done !== 1'b1 || obs_ser !== 1'b1 || obs_busy !== 1'b1) begin
      bad++;
      $display("FAIL %s done_cycle: done=%b serial=%b busy=%b, want 1 1 1",
               name, obs_done, obs_ser, obs_busy);
    end
    if (exp_cycles > 0) begin
      total++;
      if (cyc_since != exp_cycles) begin
        bad++;
        $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc_since, exp_cycles);
      end
    end
    if (exp_rise >= 0) begin
      total++;
      if (rise != exp_rise) begin
        bad++;
        $display("FAIL %s start_len: first high at %0d cycles, want %0d", name, rise, exp_rise);
      end
    end
    if (inject_done) begin
      tx_start = 1'b1;
      tx_data  = 8'h3C;
    end
    @(negedge clk);
    tx_start = 1'b0;
    total++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_ser !== 1'b1) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b serial=%b, want 0 0 1",
               name, obs_done, obs_busy, obs_ser);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      total++;
      if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_state[%0d]: serial=%b busy=%b done=%b, want 1 0 0",
                 i, obs_ser, obs_busy, obs_done);
      end
    end
    reset = 1'b0;
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    sel = 0;
    send(8'hA5, 1);
    run_frame("8n1_A5", 640, 64, -1, 0, -1);
  endtask

  task automatic test_parity();
    sel = 1;
    send(8'h07, 1);
    run_frame("8e1_07", 704, -1, -1, 0, -1);
    sel = 2;
    send(8'h07, 2);
    run_frame("8o1_07", 0, -1, -1, 0, -1);
    sel = 1;
    send(8'hC3, 0);
    run_frame("8e1_C3", 0, -1, -1, 0, -1);
  endtask

  task automatic test_7n2();
    sel = 3;
    send(8'h55, 1);
    run_frame("7n2_55", 640, -1, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    send(8'h96, 2);
    run_frame("ignore_96", 0, -1, 70, 1, -1);
    send(8'h4E, 3);
    run_frame("b2b_4E", 0, -1, -1, 0, -1);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    send(8'hFF, 2);
    run_frame("reset_FF", 0, -1, -1, 0, 16 * 4 + 5);
    send(8'h81, 0);
    run_frame("after_reset_81", 0, -1, -1, 0, -1);
  endtask

  task automatic test_coincident();
    sel = 0;
    send(8'h01, 1);
    run_frame("coincident_01", 640, 64, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_reset_mid();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
